// File: rtl/stage_mem_lsu_pkg.sv
// Shared types and constants for the MEM stage load/store unit.
// Holds the FSM state enum, load funct3 codes and access-size masks.
package stage_mem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [7:0] WM_B = 8'h01;
    localparam logic [7:0] WM_H = 8'h03;
    localparam logic [7:0] WM_W = 8'h0F;
    localparam logic [7:0] WM_D = 8'hFF;

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] align_mask(input logic [7:0] wm);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, wm[i]};
        end
        return 3'(n - 4'd1);
    endfunction

endpackage

// File: rtl/stage_mem_lsu_if.sv
// Data-memory request/response bus (valid/grant/rvalid).
// master = load/store unit side, slave = memory side.
interface stage_mem_lsu_if;

    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o,
        output dmem_wdata_o, dmem_be_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o,
        input  dmem_wdata_o, dmem_be_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

endinterface

// File: rtl/stage_mem_lsu_load_align.sv
// Load data alignment: shift the 64-bit read word down by the byte
// offset, then sign/zero-extend by funct3. Ports: rdata_i, off_i, funct3_i -> load_data_o.
module mem_load_align
    import stage_mem_lsu_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] load_data_o
);

    logic [63:0] sh;

    always_comb begin
        sh = rdata_i >> {off_i, 3'b000};
        load_data_o = '0;
        unique case (funct3_i)
            F3_LB:   load_data_o = {{56{sh[7]}}, sh[7:0]};
            F3_LH:   load_data_o = {{48{sh[15]}}, sh[15:0]};
            F3_LW:   load_data_o = {{32{sh[31]}}, sh[31:0]};
            F3_LD:   load_data_o = sh;
            F3_LBU:  load_data_o = {56'h0, sh[7:0]};
            F3_LHU:  load_data_o = {48'h0, sh[15:0]};
            F3_LWU:  load_data_o = {32'h0, sh[31:0]};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM stage + MEM/WB register: issues dmem transactions, stalls until done.
// Ports: EXE/MEM bundle in, dmem master bus, stall_o, registered WB bundle out.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              RegWrite,
    input  logic [1:0]        MemToReg,
    input  logic [7:0]        wmask,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       inst_in,
    output logic              stall_o,
    stage_mem_lsu_if.master   dmem,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic [4:0]        rd_o,
    output logic              RegWrite_o,
    output logic [1:0]        MemToReg_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              misaligned_o,
    output logic              bus_err_o
);

    localparam int CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]  off;
    logic        mem_op, misal, idle_err;
    logic        stall_c, wb_load, rsp_ok, timeout, in_req;
    logic [63:0] ld_aligned;

    logic        wb_valid_q, rw_q, mis_q, berr_q;
    logic [63:0] alu_q, load_q;
    logic [4:0]  rd_q;
    logic [1:0]  m2r_q;
    logic [31:0] pc_q, inst_q;

    assign off      = ALUResult[2:0];
    assign mem_op   = valid_in & (MemRead | MemWrite);
    assign misal    = |(off & align_mask(wmask));
    assign idle_err = (state_q == IDLE) & mem_op;

    mem_load_align u_align (
        .rdata_i     (dmem.dmem_rdata_i),
        .off_i       (off),
        .funct3_i    (inst_in[14:12]),
        .load_data_o (ld_aligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        wb_load = 1'b0;
        rsp_ok  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op && !misal) begin
                    stall_c = 1'b1;
                    state_d = REQ;
                end else begin
                    wb_load = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                // rvalid seen together with gnt belongs to nothing yet
                if (dmem.dmem_gnt_i) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem.dmem_rvalid_i) begin
                    rsp_ok  = 1'b1;
                    wb_load = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    timeout = 1'b1;
                    wb_load = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by nrst so the hold releases as soon as reset asserts.
    assign stall_o = stall_c & nrst;

    assign in_req             = (state_q == REQ);
    assign dmem.dmem_req_o    = in_req;
    assign dmem.dmem_we_o     = in_req & MemWrite;
    assign dmem.dmem_addr_o   = in_req ? {ALUResult[63:3], 3'b000} : '0;
    assign dmem.dmem_be_o     = in_req ? (wmask << off) : '0;
    assign dmem.dmem_wdata_o  = in_req ? (rd_data2 << {off, 3'b000}) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            alu_q      <= '0;
            load_q     <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            m2r_q      <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wb_load) begin
                wb_valid_q <= valid_in;
                alu_q      <= ALUResult;
                load_q     <= (rsp_ok & MemRead) ? ld_aligned : '0;
                rd_q       <= inst_in[11:7];
                rw_q       <= valid_in & RegWrite & ~idle_err & ~timeout;
                m2r_q      <= MemToReg;
                pc_q       <= pc_in;
                inst_q     <= inst_in;
                mis_q      <= idle_err;
                berr_q     <= timeout;
            end else begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign alu_result_o = alu_q;
    assign load_data_o  = load_q;
    assign rd_o         = rd_q;
    assign RegWrite_o   = rw_q;
    assign MemToReg_o   = m2r_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign misaligned_o = mis_q;
    assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Testbench for stage_mem_lsu: directed ops, scoreboard queues for
// dmem requests and WB results, checked by separate monitors.
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        valid_in = 1'b0;
    logic [63:0] ALUResult = '0;
    logic [63:0] rd_data2 = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        RegWrite = 1'b0;
    logic [1:0]  MemToReg = '0;
    logic [7:0]  wmask = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] inst_in = '0;
    logic        stall_o;
    logic        wb_valid_o;
    logic [63:0] alu_result_o, load_data_o;
    logic [4:0]  rd_o;
    logic        RegWrite_o;
    logic [1:0]  MemToReg_o;
    logic [31:0] pc_o, inst_o;
    logic        misaligned_o, bus_err_o;

    stage_mem_lsu_if bus ();

    stage_mem_lsu #(.DATA_W(64), .MAX_WAIT(16)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .valid_in     (valid_in),
        .ALUResult    (ALUResult),
        .rd_data2     (rd_data2),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .wmask        (wmask),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .stall_o      (stall_o),
        .dmem         (bus),
        .wb_valid_o   (wb_valid_o),
        .alu_result_o (alu_result_o),
        .load_data_o  (load_data_o),
        .rd_o         (rd_o),
        .RegWrite_o   (RegWrite_o),
        .MemToReg_o   (MemToReg_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] ld;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  m2r;
    } wb_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } rq_t;

    wb_t wbq[$];
    rq_t rqq[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // request monitor
    always @(negedge clk) begin
        if (nrst && bus.dmem_req_o && bus.dmem_gnt_i) begin
            if (rqq.size() == 0) begin
                chk("req_unexpected", 64'd1, 64'd0);
            end else begin
                rq_t r;
                r = rqq.pop_front();
                chk("req_we", bus.dmem_we_o, r.we);
                chk("req_addr", bus.dmem_addr_o, r.addr);
                chk("req_wdata", bus.dmem_wdata_o, r.wdata);
                chk("req_be", bus.dmem_be_o, r.be);
            end
        end
    end

    // write-back monitor
    always @(negedge clk) begin
        if (nrst && wb_valid_o) begin
            if (wbq.size() == 0) begin
                chk("wb_unexpected", 64'd1, 64'd0);
            end else begin
                wb_t w;
                w = wbq.pop_front();
                chk("wb_alu", alu_result_o, w.alu);
                chk("wb_load", load_data_o, w.ld);
                chk("wb_rd", rd_o, w.rd);
                chk("wb_regwrite", RegWrite_o, w.rw);
                chk("wb_misaligned", misaligned_o, w.mis);
                chk("wb_buserr", bus_err_o, w.berr);
                chk("wb_pc", pc_o, w.pc);
                chk("wb_inst", inst_o, w.inst);
                chk("wb_memtoreg", MemToReg_o, w.m2r);
            end
        end
    end

    function automatic logic [31:0] mk_inst(input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h03};
    endfunction

    task automatic exp_req(input logic we, input logic [63:0] a,
                           input logic [63:0] wd, input logic [7:0] be);
        rq_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        rqq.push_back(r);
    endtask

    task automatic exp_wb(input logic [63:0] a, input logic [63:0] ld,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input logic rw, input logic mis,
                          input logic berr, input logic [31:0] pc,
                          input logic [1:0] m2r);
        wb_t w;
        w.alu = a; w.ld = ld; w.rd = rd; w.rw = rw; w.mis = mis;
        w.berr = berr; w.pc = pc; w.inst = mk_inst(f3, rd); w.m2r = m2r;
        wbq.push_back(w);
    endtask

    // Drives one EXE/MEM op and plays memory until stall_o drops.
    // gdly: REQ cycles before gnt; lat: WAIT cycle carrying rvalid (0=never).
    task automatic run_op(
        input logic mr, input logic mw, input logic rw,
        input logic [63:0] a, input logic [63:0] d,
        input logic [7:0] wm, input logic [2:0] f3, input logic [4:0] rd,
        input logic [31:0] pc, input logic [1:0] m2r,
        input int gdly, input int lat, input logic [63:0] rdat,
        input logic dual,
        output int stalls, output int reqs, output int waits);
        int  g;
        bit  granted;
        bit  done;
        valid_in = 1'b1; MemRead = mr; MemWrite = mw; RegWrite = rw;
        ALUResult = a; rd_data2 = d; wmask = wm; pc_in = pc;
        MemToReg = m2r; inst_in = mk_inst(f3, rd);
        stalls = 0; reqs = 0; waits = 0; g = 0;
        granted = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            bus.dmem_gnt_i = 1'b0;
            bus.dmem_rvalid_i = 1'b0;
            bus.dmem_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
            #1;
            if (granted) begin
                waits++;
                if (waits == lat) begin
                    bus.dmem_rvalid_i = 1'b1;
                    bus.dmem_rdata_i = rdat;
                end
            end else if (bus.dmem_req_o) begin
                reqs++;
                if (g == gdly) begin
                    bus.dmem_gnt_i = 1'b1;
                    granted = 1;
                    if (dual) begin
                        bus.dmem_rvalid_i = 1'b1;
                        bus.dmem_rdata_i = ~rdat;
                    end
                end
                g++;
            end
            #1;
            if (stall_o) stalls++;
            else done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("op_no_complete", 64'd0, 64'd1);
        valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        bus.dmem_gnt_i = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, rq, wt;
        bus.dmem_gnt_i = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i = '0;

        #3;
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_req", bus.dmem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_alu", alu_result_o, 64'h0);
        @(posedge clk); #2;
        nrst = 1'b1;
        @(posedge clk); #1;

        // ALU op
        exp_wb(64'h1234, 64'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0,
               32'h100, 2'b00);
        run_op(1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 8'h00, 3'b000,
               5'd5, 32'h100, 2'b00, 0, 0, 64'h0, 1'b0, st, rq, wt);
        chk("alu_stalls", 64'(st), 64'd0);

        // lb 0x1003
        exp_req(1'b0, 64'h1000, 64'h0, 8'h08);
        exp_wb(64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 3'b000, 5'd6, 1'b1,
               1'b0, 1'b0, 32'h104, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h1003, 64'h0, 8'h01, 3'b000,
               5'd6, 32'h104, 2'b01, 0, 2, 64'h0000_0000_8000_0000,
               1'b0, st, rq, wt);
        chk("lb_stalls", 64'(st), 64'd3);

        // sw 0x2004, gnt after one cycle
        exp_req(1'b1, 64'h2000, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        exp_wb(64'h2004, 64'h0, 3'b010, 5'd7, 1'b0, 1'b0, 1'b0,
               32'h108, 2'b00);
        run_op(1'b0, 1'b1, 1'b0, 64'h2004, 64'hDEAD_BEEF, 8'h0F, 3'b010,
               5'd7, 32'h108, 2'b00, 1, 1, 64'h1111, 1'b0, st, rq, wt);
        chk("sw_stalls", 64'(st), 64'd3);

        // misaligned lw 0x3002
        exp_wb(64'h3002, 64'h0, 3'b010, 5'd8, 1'b0, 1'b1, 1'b0,
               32'h10C, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h3002, 64'h0, 8'h0F, 3'b010,
               5'd8, 32'h10C, 2'b01, 0, 1, 64'h0, 1'b0, st, rq, wt);
        chk("mis_stalls", 64'(st), 64'd0);
        chk("mis_reqs", 64'(rq), 64'd0);

        // ld 0x4000, gnt after 2, rvalid with gnt ignored
        exp_req(1'b0, 64'h4000, 64'h0, 8'hFF);
        exp_wb(64'h4000, 64'h0123_4567_89AB_CDEF, 3'b011, 5'd9, 1'b1,
               1'b0, 1'b0, 32'h110, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h4000, 64'h0, 8'hFF, 3'b011,
               5'd9, 32'h110, 2'b01, 2, 1, 64'h0123_4567_89AB_CDEF,
               1'b1, st, rq, wt);
        chk("ld_stalls", 64'(st), 64'd4);
        chk("ld_reqs", 64'(rq), 64'd3);

        // lh / lhu 0x5006
        exp_req(1'b0, 64'h5000, 64'h0, 8'hC0);
        exp_wb(64'h5006, 64'hFFFF_FFFF_FFFF_BEEF, 3'b001, 5'd10, 1'b1,
               1'b0, 1'b0, 32'h114, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h5006, 64'h0, 8'h03, 3'b001,
               5'd10, 32'h114, 2'b01, 0, 1, 64'hBEEF_0000_0000_0000,
               1'b0, st, rq, wt);
        exp_req(1'b0, 64'h5000, 64'h0, 8'hC0);
        exp_wb(64'h5006, 64'h0000_0000_0000_BEEF, 3'b101, 5'd11, 1'b1,
               1'b0, 1'b0, 32'h118, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h5006, 64'h0, 8'h03, 3'b101,
               5'd11, 32'h118, 2'b01, 0, 1, 64'hBEEF_0000_0000_0000,
               1'b0, st, rq, wt);

        // lw 0x6004
        exp_req(1'b0, 64'h6000, 64'h0, 8'hF0);
        exp_wb(64'h6004, 64'hFFFF_FFFF_8000_0001, 3'b010, 5'd13, 1'b1,
               1'b0, 1'b0, 32'h11C, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h6004, 64'h0, 8'h0F, 3'b010,
               5'd13, 32'h11C, 2'b01, 0, 3, 64'h8000_0001_0000_0000,
               1'b0, st, rq, wt);

        // timeout: rvalid never comes
        exp_req(1'b0, 64'h7000, 64'h0, 8'hFF);
        exp_wb(64'h7000, 64'h0, 3'b011, 5'd12, 1'b0, 1'b0, 1'b1,
               32'h120, 2'b01);
        run_op(1'b1, 1'b0, 1'b1, 64'h7000, 64'h0, 8'hFF, 3'b011,
               5'd12, 32'h120, 2'b01, 0, 0, 64'h0, 1'b0, st, rq, wt);
        chk("tmo_waits", 64'(wt), 64'd16);

        // late rvalid in IDLE must not produce a WB slot
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i = 64'hFFFF;
        @(posedge clk); #1;
        bus.dmem_rvalid_i = 1'b0;
        chk("late_stall", stall_o, 1'b0);

        // back-to-back ALU op: FSM idle again, latency 1
        exp_wb(64'hABCD, 64'h0, 3'b000, 5'd14, 1'b1, 1'b0, 1'b0,
               32'h124, 2'b00);
        run_op(1'b0, 1'b0, 1'b1, 64'hABCD, 64'h0, 8'h00, 3'b000,
               5'd14, 32'h124, 2'b00, 0, 0, 64'h0, 1'b0, st, rq, wt);
        chk("alu2_stalls", 64'(st), 64'd0);

        // reset while a request is outstanding
        valid_in = 1'b1; MemRead = 1'b1; RegWrite = 1'b1;
        ALUResult = 64'h8000; wmask = 8'hFF; inst_in = mk_inst(3'b011, 5'd3);
        @(posedge clk); #1;
        chk("rst_mid_req_before", bus.dmem_req_o, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_mid_req", bus.dmem_req_o, 1'b0);
        chk("rst_mid_stall", stall_o, 1'b0);
        chk("rst_mid_alu", alu_result_o, 64'h0);
        chk("rst_mid_pc", pc_o, 32'h0);
        chk("rst_mid_rw", RegWrite_o, 1'b0);
        valid_in = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        bus.dmem_rvalid_i = 1'b1;
        @(posedge clk); #1;
        bus.dmem_rvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_after_wb_valid", wb_valid_o, 1'b0);

        chk("wbq_drained", 64'(wbq.size()), 64'd0);
        chk("rqq_drained", 64'(rqq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
